// File: rtl/mm_rf_pkg.sv
// Shared defaults and sizing helpers for the multimedia vector register file.
package mm_rf_pkg;

  localparam int unsigned DEF_REG_WIDTH  = 128;
  localparam int unsigned DEF_REG_COUNT  = 32;
  localparam int unsigned DEF_LANE_WIDTH = 16;
  localparam int unsigned DEF_NUM_READ   = 3;
  localparam int unsigned DEF_NUM_WRITE  = 2;
  localparam int unsigned DEF_CNT_WIDTH  = 8;

  // Number of write-mask lanes in one register.
  function automatic int unsigned lane_count(input int unsigned reg_width,
                                             input int unsigned lane_width);
    return reg_width / lane_width;
  endfunction

  // Register address width; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned reg_count);
    return (reg_count > 1) ? $clog2(reg_count) : 1;
  endfunction

endpackage

// File: rtl/mm_rf_lane_merge.sv
// Priority lane merge of all write ports that target one address. The highest-index
// port enabling a lane wins; hit_mask flags lanes that any enabled port writes.
module mm_rf_lane_merge
  import mm_rf_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int unsigned NUM_WRITE  = DEF_NUM_WRITE,
  parameter int unsigned AW         = addr_width(DEF_REG_COUNT),
  parameter int unsigned LANES      = lane_count(REG_WIDTH, LANE_WIDTH)
) (
  input  logic [AW-1:0]                  addr,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE*AW-1:0]        wr_addr,
  input  logic [NUM_WRITE*LANES-1:0]     wr_mask,
  input  logic [NUM_WRITE*REG_WIDTH-1:0] wr_data,
  output logic [REG_WIDTH-1:0]           merged_data,
  output logic [LANES-1:0]               hit_mask
);

  // Walk ports in ascending order so later (higher-index) ports override earlier ones.
  always_comb begin
    merged_data = '0;
    hit_mask    = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
        for (int l = 0; l < LANES; l++) begin
          if (wr_mask[p*LANES + l]) begin
            merged_data[l*LANE_WIDTH +: LANE_WIDTH] =
                wr_data[p*REG_WIDTH + l*LANE_WIDTH +: LANE_WIDTH];
            hit_mask[l] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mm_vreg_file.sv
// Multi-ported SIMD register file with lane-masked writes, same-cycle read bypass,
// a busy scoreboard for in-flight producers and write-collision debug counters.
module mm_vreg_file
  import mm_rf_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned REG_COUNT  = DEF_REG_COUNT,
  parameter int unsigned LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int unsigned NUM_READ   = DEF_NUM_READ,
  parameter int unsigned NUM_WRITE  = DEF_NUM_WRITE,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int unsigned AW        = addr_width(REG_COUNT),
  localparam int unsigned LANES     = lane_count(REG_WIDTH, LANE_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE*AW-1:0]        wr_addr,
  input  logic [NUM_WRITE*LANES-1:0]     wr_mask,
  input  logic [NUM_WRITE*REG_WIDTH-1:0] wr_data,
  input  logic [NUM_READ*AW-1:0]         rd_addr,
  output logic [NUM_READ*REG_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           issue_en,
  input  logic [AW-1:0]                  issue_addr,
  output logic [REG_COUNT-1:0]           busy_vec,
  output logic                           wr_collision,
  output logic [CNT_WIDTH-1:0]           collision_cnt,
  output logic [REG_WIDTH*REG_COUNT-1:0] reg_data_all
);

  logic [REG_WIDTH*REG_COUNT-1:0] regs_q, regs_d;
  logic [REG_WIDTH-1:0]           regs_arr [REG_COUNT];
  logic [REG_COUNT-1:0]           busy_q, busy_d;
  logic [REG_COUNT-1:0]           wr_tgt;
  logic                           collision;
  logic                           coll_q;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;

  // Register 0 is hardwired to zero; every other register merges its own writes.
  assign regs_d[0 +: REG_WIDTH] = '0;
  assign regs_arr[0]            = regs_q[0 +: REG_WIDTH];

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
    logic [REG_WIDTH-1:0] wdata;
    logic [LANES-1:0]     whit;

    mm_rf_lane_merge #(
      .REG_WIDTH (REG_WIDTH),
      .LANE_WIDTH(LANE_WIDTH),
      .NUM_WRITE (NUM_WRITE),
      .AW        (AW),
      .LANES     (LANES)
    ) u_wr_merge (
      .addr       (AW'(g)),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .merged_data(wdata),
      .hit_mask   (whit)
    );

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign regs_d[g*REG_WIDTH + l*LANE_WIDTH +: LANE_WIDTH] =
          whit[l] ? wdata[l*LANE_WIDTH +: LANE_WIDTH]
                  : regs_q[g*REG_WIDTH + l*LANE_WIDTH +: LANE_WIDTH];
    end

    assign regs_arr[g] = regs_q[g*REG_WIDTH +: REG_WIDTH];
  end

  // Registers touched by any enabled write port this cycle, mask ignored.
  always_comb begin
    wr_tgt = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) wr_tgt[r] = 1'b1;
      end
    end
  end

  // Read ports: zero for r0, else per-lane bypass of same-cycle writes over stored data.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0]        ra;
    logic [REG_WIDTH-1:0] bdata;
    logic [LANES-1:0]     bhit;

    assign ra = rd_addr[k*AW +: AW];

    mm_rf_lane_merge #(
      .REG_WIDTH (REG_WIDTH),
      .LANE_WIDTH(LANE_WIDTH),
      .NUM_WRITE (NUM_WRITE),
      .AW        (AW),
      .LANES     (LANES)
    ) u_rd_merge (
      .addr       (ra),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_mask    (wr_mask),
      .wr_data    (wr_data),
      .merged_data(bdata),
      .hit_mask   (bhit)
    );

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign rd_data[k*REG_WIDTH + l*LANE_WIDTH +: LANE_WIDTH] =
          (ra == '0) ? '0 :
          bhit[l]    ? bdata[l*LANE_WIDTH +: LANE_WIDTH]
                     : regs_arr[ra][l*LANE_WIDTH +: LANE_WIDTH];
    end

    // A write landing this cycle retires the producer, so the reader need not stall.
    assign rd_busy[k] = (ra != '0) && busy_q[ra] && !wr_tgt[ra];
  end

  // Scoreboard next state: writes clear, a new issue sets and wins over a clear.
  always_comb begin
    busy_d = busy_q & ~wr_tgt;
    if (issue_en && (issue_addr != '0)) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Collision: two enabled ports on the same nonzero register with overlapping lanes.
  always_comb begin
    collision = 1'b0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      for (int q = p + 1; q < NUM_WRITE; q++) begin
        if (wr_en[p] && wr_en[q] &&
            (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]) &&
            (wr_addr[p*AW +: AW] != '0) &&
            |(wr_mask[p*LANES +: LANES] & wr_mask[q*LANES +: LANES])) begin
          collision = 1'b1;
        end
      end
    end
  end

  // Saturating collision counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (collision && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // State update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      busy_q <= '0;
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      coll_q <= collision;
      cnt_q  <= cnt_d;
    end
  end

  assign reg_data_all  = regs_q;
  assign busy_vec      = busy_q;
  assign wr_collision  = coll_q;
  assign collision_cnt = cnt_q;

endmodule

// File: tb/tb_mm_vreg_file.sv
// Self-checking bench for mm_vreg_file: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file.
module tb_mm_vreg_file;

  localparam int RW = 128;
  localparam int RC = 32;
  localparam int LW = 16;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int CW = 8;
  localparam int AW = 5;
  localparam int LN = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*LN-1:0]  wr_mask;
  logic [NW*RW-1:0]  wr_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*RW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic [RC-1:0]     busy_vec;
  logic              wr_collision;
  logic [CW-1:0]     collision_cnt;
  logic [RW*RC-1:0]  reg_data_all;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [RW-1:0] m_reg [RC];
  bit            m_busy [RC];
  bit            m_coll;
  int            m_cnt;

  mm_vreg_file dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_mask      (wr_mask),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .issue_en     (issue_en),
    .issue_addr   (issue_addr),
    .busy_vec     (busy_vec),
    .wr_collision (wr_collision),
    .collision_cnt(collision_cnt),
    .reg_data_all (reg_data_all)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  task automatic set_wr(input int p, input bit en, input int a, input logic [LN-1:0] m,
                        input logic [RW-1:0] d);
    wr_en[p]              = en;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_mask[p*LN +: LN]   = m;
    wr_data[p*RW +: RW]   = d;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_mask    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] dut_reg(input int a);
    return reg_data_all[a*RW +: RW];
  endfunction

  function automatic logic [RW-1:0] dut_rd(input int k);
    return rd_data[k*RW +: RW];
  endfunction

  function automatic logic [RW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  // Register content after the coming edge: each lane takes the last port (in index order)
  // that writes it; register 0 is always zero.
  function automatic logic [RW-1:0] model_next(input int a);
    logic [RW-1:0] r;
    if (a == 0) return '0;
    r = m_reg[a];
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a)
        for (int l = 0; l < LN; l++)
          if (wr_mask[p*LN + l]) r[l*LW +: LW] = wr_data[p*RW + l*LW +: LW];
    return r;
  endfunction

  function automatic bit model_rd_busy(input int a);
    if (a == 0) return 1'b0;
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_step();
    logic [RW-1:0] nr [RC];
    bit coll;
    for (int a = 0; a < RC; a++) nr[a] = model_next(a);
    for (int p = 0; p < NW; p++)
      if (wr_en[p]) m_busy[int'(wr_addr[p*AW +: AW])] = 1'b0;
    if (issue_en && issue_addr != 0) m_busy[int'(issue_addr)] = 1'b1;
    coll = 1'b0;
    for (int p = 0; p < NW; p++)
      for (int q = p + 1; q < NW; q++)
        if (wr_en[p] && wr_en[q] && wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW] &&
            wr_addr[p*AW +: AW] != 0 && (wr_mask[p*LN +: LN] & wr_mask[q*LN +: LN]) != 0)
          coll = 1'b1;
    for (int a = 0; a < RC; a++) m_reg[a] = nr[a];
    m_coll = coll;
    if (coll && m_cnt < 255) m_cnt++;
  endtask

  task automatic model_reset();
    for (int a = 0; a < RC; a++) begin
      m_reg[a]  = '0;
      m_busy[a] = 1'b0;
    end
    m_coll = 1'b0;
    m_cnt  = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle();
    rd_addr = '0;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (reg_data_all !== '0) begin
      n_err++; $display("FAIL reset_regs got nonzero register contents, required all zero");
    end
    n_cmp++;
    if (busy_vec !== '0) begin
      n_err++; $display("FAIL reset_busy got %h required 0", busy_vec);
    end
    n_cmp++;
    if (wr_collision !== 1'b0 || collision_cnt !== '0) begin
      n_err++; $display("FAIL reset_coll got %b/%0d required 0/0", wr_collision, collision_cnt);
    end
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (reg_data_all !== '0 || busy_vec !== '0) begin
      n_err++; $display("FAIL reset_hold state changed after release with idle inputs");
    end
  endtask

  task automatic test_basic_write();
    logic [RW-1:0] pat;
    pat = {16{8'hA5}};
    set_wr(0, 1'b1, 5, 8'hFF, pat);
    model_step();
    tick();
    idle();
    n_cmp++;
    if (dut_reg(5) !== pat) begin
      n_err++; $display("FAIL basic_reg5 got %h required %h", dut_reg(5), pat);
    end
    set_rd(0, 0);
    set_rd(1, 5);
    #1;
    n_cmp++;
    if (dut_rd(0) !== '0) begin
      n_err++; $display("FAIL basic_rd0 got %h required 0", dut_rd(0));
    end
    n_cmp++;
    if (dut_rd(1) !== pat) begin
      n_err++; $display("FAIL basic_rd5 got %h required %h", dut_rd(1), pat);
    end
    set_wr(0, 1'b1, 0, 8'hFF, {RW{1'b1}});
    #1;
    n_cmp++;
    if (dut_rd(0) !== '0) begin
      n_err++; $display("FAIL basic_rd0_bypass got %h required 0", dut_rd(0));
    end
    model_step();
    tick();
    idle();
    n_cmp++;
    if (dut_reg(0) !== '0) begin
      n_err++; $display("FAIL basic_reg0_write got %h required 0", dut_reg(0));
    end
  endtask

  task automatic test_lane_merge();
    logic [RW-1:0] expv;
    set_wr(0, 1'b1, 3, 8'hFF, {8{16'h3333}});
    model_step();
    tick();
    idle();
    set_wr(0, 1'b1, 3, 8'h0F, {8{16'h1111}});
    set_wr(1, 1'b1, 3, 8'h3C, {8{16'h2222}});
    model_step();
    tick();
    idle();
    expv = {16'h3333, 16'h3333, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h1111, 16'h1111};
    n_cmp++;
    if (dut_reg(3) !== expv) begin
      n_err++; $display("FAIL merge_reg3 got %h required %h", dut_reg(3), expv);
    end
    n_cmp++;
    if (wr_collision !== 1'b1) begin
      n_err++; $display("FAIL merge_coll_pulse got %b required 1", wr_collision);
    end
    n_cmp++;
    if (collision_cnt !== 8'd1) begin
      n_err++; $display("FAIL merge_coll_cnt got %0d required 1", collision_cnt);
    end
    model_step();
    tick();
    n_cmp++;
    if (wr_collision !== 1'b0 || collision_cnt !== 8'd1) begin
      n_err++; $display("FAIL merge_coll_after got %b/%0d required 0/1", wr_collision,
                        collision_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [RW-1:0] oldv, newd, expv;
    oldv = rand_word();
    newd = rand_word();
    set_wr(0, 1'b1, 7, 8'hFF, oldv);
    model_step();
    tick();
    idle();
    set_rd(0, 7);
    set_wr(1, 1'b1, 7, 8'h01, newd);
    #3;
    expv = {oldv[RW-1:LW], newd[LW-1:0]};
    n_cmp++;
    if (dut_rd(0) !== expv) begin
      n_err++; $display("FAIL bypass_rd got %h required %h", dut_rd(0), expv);
    end
    n_cmp++;
    if (dut_reg(7) !== oldv) begin
      n_err++; $display("FAIL bypass_stored_early got %h required %h", dut_reg(7), oldv);
    end
    model_step();
    tick();
    idle();
    n_cmp++;
    if (dut_reg(7) !== expv) begin
      n_err++; $display("FAIL bypass_reg7 got %h required %h", dut_reg(7), expv);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue_en = 1'b1;
    issue_addr = 5'd9;
    model_step();
    tick();
    idle();
    set_rd(1, 9);
    #1;
    n_cmp++;
    if (busy_vec[9] !== 1'b1) begin
      n_err++; $display("FAIL sb_set got %b required 1", busy_vec[9]);
    end
    n_cmp++;
    if (rd_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL sb_rd_busy got %b required 1", rd_busy[1]);
    end
    set_wr(0, 1'b1, 9, 8'h00, rand_word());
    #1;
    n_cmp++;
    if (rd_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL sb_rd_busy_wr got %b required 0", rd_busy[1]);
    end
    model_step();
    tick();
    idle();
    n_cmp++;
    if (busy_vec[9] !== 1'b0) begin
      n_err++; $display("FAIL sb_clear got %b required 0", busy_vec[9]);
    end
    n_cmp++;
    if (dut_reg(9) !== '0) begin
      n_err++; $display("FAIL sb_mask0_data got %h required 0", dut_reg(9));
    end
    issue_en = 1'b1;
    issue_addr = 5'd9;
    model_step();
    tick();
    set_wr(1, 1'b1, 9, 8'hFF, rand_word());
    model_step();
    tick();
    idle();
    n_cmp++;
    if (busy_vec[9] !== 1'b1) begin
      n_err++; $display("FAIL sb_set_wins got %b required 1", busy_vec[9]);
    end
    issue_en = 1'b1;
    issue_addr = 5'd0;
    set_rd(2, 0);
    model_step();
    tick();
    idle();
    n_cmp++;
    if (busy_vec[0] !== 1'b0 || rd_busy[2] !== 1'b0) begin
      n_err++; $display("FAIL sb_reg0 got %b/%b required 0/0", busy_vec[0], rd_busy[2]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int p = 0; p < NW; p++)
        set_wr(p, $urandom_range(0, 3) != 0, $urandom_range(0, 7), LN'($urandom), rand_word());
      for (int k = 0; k < NR; k++)
        set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, RC - 1) : $urandom_range(0, 7));
      issue_en   = $urandom_range(0, 1) == 1;
      issue_addr = AW'($urandom_range(0, 7));
      #3;
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (dut_rd(k) !== model_next(int'(rd_addr[k*AW +: AW]))) begin
          n_err++; $display("FAIL rand_rd_data port %0d cycle %0d got %h required %h", k, c,
                            dut_rd(k), model_next(int'(rd_addr[k*AW +: AW])));
        end
        n_cmp++;
        if (rd_busy[k] !== model_rd_busy(int'(rd_addr[k*AW +: AW]))) begin
          n_err++; $display("FAIL rand_rd_busy port %0d cycle %0d got %b required %b", k, c,
                            rd_busy[k], model_rd_busy(int'(rd_addr[k*AW +: AW])));
        end
      end
      model_step();
      tick();
      for (int a = 0; a < RC; a++) begin
        n_cmp++;
        if (dut_reg(a) !== m_reg[a] || busy_vec[a] !== m_busy[a]) begin
          n_err++; $display("FAIL rand_state reg %0d cycle %0d got %h/%b required %h/%b", a, c,
                            dut_reg(a), busy_vec[a], m_reg[a], m_busy[a]);
        end
      end
      n_cmp++;
      if (wr_collision !== m_coll || int'(collision_cnt) != m_cnt) begin
        n_err++; $display("FAIL rand_coll cycle %0d got %b/%0d required %b/%0d", c,
                          wr_collision, collision_cnt, m_coll, m_cnt);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    set_wr(0, 1'b1, 1, 8'hFF, rand_word());
    set_wr(1, 1'b1, 1, 8'hFF, rand_word());
    for (int c = 0; c < 300; c++) begin
      model_step();
      tick();
    end
    n_cmp++;
    if (collision_cnt !== 8'hFF || wr_collision !== 1'b1) begin
      n_err++; $display("FAIL sat_cnt got %0d/%b required 255/1", collision_cnt, wr_collision);
    end
    idle();
    model_step();
    tick();
    n_cmp++;
    if (collision_cnt !== 8'hFF || wr_collision !== 1'b0) begin
      n_err++; $display("FAIL sat_hold got %0d/%b required 255/0", collision_cnt, wr_collision);
    end
  endtask

  task automatic test_async_reset();
    idle();
    set_wr(0, 1'b1, 4, 8'hFF, {RW{1'b1}});
    issue_en = 1'b1;
    issue_addr = 5'd12;
    model_step();
    tick();
    n_cmp++;
    if (dut_reg(4) !== {RW{1'b1}} || busy_vec[12] !== 1'b1) begin
      n_err++; $display("FAIL areset_setup got %h/%b required all-ones/1", dut_reg(4),
                        busy_vec[12]);
    end
    set_wr(0, 1'b1, 6, 8'hFF, {RW{1'b1}});
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (reg_data_all !== '0 || busy_vec !== '0) begin
      n_err++; $display("FAIL areset_state busy got %h required 0 (registers must be zero)",
                        busy_vec);
    end
    n_cmp++;
    if (wr_collision !== 1'b0 || collision_cnt !== '0) begin
      n_err++; $display("FAIL areset_coll got %b/%0d required 0/0", wr_collision,
                        collision_cnt);
    end
    tick();
    n_cmp++;
    if (dut_reg(6) !== '0) begin
      n_err++; $display("FAIL areset_no_write got %h required 0", dut_reg(6));
    end
    idle();
    model_reset();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_lane_merge();
    test_bypass();
    test_scoreboard();
    test_random();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mm_vreg_file.md
Name: mm_vreg_file

Overview:
- Next-generation multimedia register file: parametrised read and write port counts, per-lane write masks, same-cycle lane-merged bypass, and a busy scoreboard for in-flight producers.
- Sits between decode/issue and the SIMD execute/writeback stages.
- Register 0 reads zero and is never written.
- Flags and counts multi-port write collisions for debug.

Parameters:
- REG_WIDTH, 128, bits per register.
- REG_COUNT, 32, number of registers; AW = $clog2(REG_COUNT).
- LANE_WIDTH, 16, bits per write-mask lane; LANES = REG_WIDTH/LANE_WIDTH. REG_WIDTH must be divisible by LANE_WIDTH.
- NUM_READ, 3, read ports.
- NUM_WRITE, 2, write ports.
- CNT_WIDTH, 8, collision counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- wr_en  in  NUM_WRITE  per-port write enable.
- wr_addr  in  NUM_WRITE*AW  packed write addresses; port p occupies slice [p*AW +: AW].
- wr_mask  in  NUM_WRITE*LANES  per-port lane enables.
- wr_data  in  NUM_WRITE*REG_WIDTH  packed write data.
- rd_addr  in  NUM_READ*AW  packed read addresses.
- rd_data  out  NUM_READ*REG_WIDTH  bypassed read data (combinational).
- rd_busy  out  NUM_READ  target register has an outstanding producer.
- issue_en  in  1  mark issue_addr busy.
- issue_addr  in  AW  destination of the newly issued instruction.
- busy_vec  out  REG_COUNT  scoreboard state.
- wr_collision  out  1  registered pulse: collision detected in the previous cycle.
- collision_cnt  out  CNT_WIDTH  saturating collision count.
- reg_data_all  out  REG_WIDTH*REG_COUNT  flattened register contents; register g at [g*REG_WIDTH +: REG_WIDTH].

Behaviour:
- Reset (reset=0, async): all registers 0, busy_vec 0, wr_collision 0, collision_cnt 0. Outputs hold these values until the first clk edge after reset deasserts.
- Write (posedge): for each lane L of register r≠0, the new value comes from the highest-index port p with wr_en[p], wr_addr[p]==r and wr_mask[p][L]. If no port qualifies, the lane is unchanged.
  - Writes to r=0 are ignored.
  - wr_mask all-zero with wr_en=1 changes no data but still counts as a write for the scoreboard.
- Read (combinational, zero latency):
  - rd_addr==0 -> all zeros.
  - Otherwise each lane is the same-cycle merged write value if any enabled port writes that lane of that address, else the stored lane.
  - Result equals the post-edge register content.
- Scoreboard (posedge):
  - busy[r] clears when any wr_en port targets r.
  - busy[r] sets when issue_en and issue_addr==r≠0.
  - Set wins over a simultaneous clear (new producer).
  - Issue to r=0 is ignored; busy[0] is always 0.
- rd_busy[k] = busy[rd_addr_k] and no enabled write port targets rd_addr_k this cycle. rd_addr_k==0 -> 0.
- Collision: in a cycle, two enabled ports share a nonzero address and have overlapping masks.
  - wr_collision=1 on the next cycle only.
  - collision_cnt increments by 1 per colliding cycle and saturates at all-ones (no wrap).
  - Writes still resolve by port priority.
- Reset asserted mid-write: no write completes; state is zero immediately, not at the next edge.

Decomposition:
- Package mm_rf_pkg: default width/count/lane constants, lane_count and addr_width functions.
- Sub-module mm_rf_lane_merge: combinational priority lane merge of NUM_WRITE ports for one address, returning merged data and a hit mask. Used once per read port for bypass, and once per register in the write path (or a shared equivalent).

Test Plan:
- Reset with reset=0, then write port0 addr 5, mask 0xFF, data all 0xA5 -> next cycle reg 5 = all 0xA5; reg 0 read = 0; a port0 write to addr 0 leaves reg 0 = 0.
- Same cycle: port0 writes addr 3, mask 0x0F, data 0x1111…; port1 writes addr 3, mask 0x3C, data 0x2222… Expect:
  - Lanes 0-1 = 0x1111, lanes 2-5 = 0x2222, lanes 6-7 unchanged.
  - wr_collision = 1 the next cycle; collision_cnt = 1.
- rd_addr0 = 7 while port1 writes addr 7, mask 0x01 -> rd_data0 shows the new lane 0 and the old lanes 1-7 in the same cycle.
- Scoreboard:
  - issue_en to addr 9 -> busy_vec[9] = 1 next cycle; rd_busy = 1 for rd_addr = 9.
  - Write to 9 -> rd_busy = 0 that cycle and busy clears next cycle.
  - Simultaneous issue and write to 9 -> busy stays 1.
- Force 300 colliding cycles with CNT_WIDTH = 8 -> collision_cnt = 255 and holds.
- Assert reset asynchronously between edges with busy and data nonzero -> all outputs zero before the next clk edge.
